// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX arbitration slice.
//   BYTE_W      : width of one UART data byte
//   ST_*        : arbiter state encoding (also exported on state_dbg)
//   clog2()     : constant-function ceil(log2(n)) used for index widths
package uart_pkg;

    localparam int BYTE_W = 8;

    // Arbiter state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Rotates req so that bit ptr lands at position 0, priority-encodes the
// lowest set bit, then adds ptr back (mod N) to get the absolute index.
// Ports:
//   req   in  N   request vector
//   ptr   in  GW  highest-priority index (must be < N)
//   idx   out GW  winning index (valid only when found=1)
//   found out 1   at least one request is set
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] idx,
    output logic          found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             enc;
    int             sum;

    always_comb begin
        // Doubling the vector turns the rotate into a plain right shift
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        found = |req;
        enc   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) enc = k;
        end
        // Un-rotate; wraps at N so non-power-of-two N never yields an out-of-range index
        sum = int'(ptr) + enc;
        if (sum >= N) sum = sum - N;
        idx = GW'(sum);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core among N byte-stream requesters
// with round-robin fairness and frame-locked grants (the owner keeps the
// transmitter until it sends a byte flagged last). cts=0 blocks new bytes
// but never interrupts a byte in flight.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   Adds parameter TMO_CYC and output tmo_err. A watchdog counts cycles in
//   WAIT_BUSY and HOLD; on expiry the lock is dropped and the arbiter
//   returns to IDLE with the pointer moved past the stalled owner.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req/req_data/req_last : per-requester byte valid, byte ([8i+7:8i]), last flag
//   ack       : one-cycle pulse, byte of requester i accepted
//   cts       : clear-to-send from the receive side
//   TxD_start/TxD_data/TxD_busy : UART TX core interface
//   grant_id  : current (or most recent) owner
//   active    : frame lock held
//   tmo_err   : sticky watchdog flag (UART_ARB_TIMEOUT_EN only)
//   state_dbg : current FSM state (ST_* encoding)
//
// Handshake: a requester raises req[i] with req_data/req_last valid and holds
// all three stable through the cycle in which ack[i] is high; the byte is
// transferred in that ack cycle. Dropping req before ack withdraws the byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = clog2(N)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 65535
`endif
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [N-1:0]        req,
    input  logic [BYTE_W*N-1:0] req_data,
    input  logic [N-1:0]        req_last,
    output logic [N-1:0]        ack,
    input  logic                cts,
    output logic                TxD_start,
    output logic [BYTE_W-1:0]   TxD_data,
    input  logic                TxD_busy,
    output logic [GW-1:0]       grant_id,
    output logic                active,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                tmo_err,
`endif
    output logic [2:0]          state_dbg
);

    logic [2:0]    state;
    logic [GW-1:0] rr_ptr;
    logic          last_q;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic [GW-1:0] next_ptr;
    logic          own_req;
    logic          tmo_hit;

    rr_pick #(.N(N), .GW(GW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign next_ptr  = (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
    assign own_req   = req[grant_id];
    assign TxD_start = (state == ST_ISSUE);
    assign ack       = TxD_start ? (N'(1) << grant_id) : '0;
    assign state_dbg = state;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          counting;

    // WAIT_BUSY and HOLD are never adjacent, so clearing outside them is
    // the same as clearing on every state change.
    assign counting = (state == ST_WAIT_BUSY) || (state == ST_HOLD);
    assign tmo_hit  = counting && (tmo_cnt == TW'(TMO_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else if (tmo_hit) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b1;
        end else if (counting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            last_q   <= 1'b0;
            grant_id <= '0;
            TxD_data <= '0;
            active   <= 1'b0;
        end else if (tmo_hit) begin
            state  <= ST_IDLE;
            active <= 1'b0;
            rr_ptr <= next_ptr;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cts && pick_found) begin
                        grant_id <= pick_idx;
                        TxD_data <= req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
                        active   <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last_q <= req_last[grant_id];
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (TxD_busy) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!TxD_busy) begin
                        if (last_q) begin
                            active <= 1'b0;
                            rr_ptr <= next_ptr;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Only the owner is considered; the lock survives the owner dropping req
                    if (own_req && cts) begin
                        TxD_data <= req_data[int'(grant_id)*BYTE_W +: BYTE_W];
                        state    <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
